// File: rtl/wb_write_queue.sv
// wb_write_queue: merges ALU results and queued load results onto one bank write port, with RAW hazard flags.
// Optional forwarding outputs (fwd*_data, fwd*_hit) are enabled by defining WBQ_BYPASS_EN.
module wb_write_queue #(
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [5:0]  alu_reg,
  input  logic [63:0] alu_data,
  input  logic        ld_valid,
  input  logic [5:0]  ld_reg,
  input  logic [63:0] ld_data,
  output logic        ld_ready,
  input  logic [5:0]  rd_reg1,
  input  logic [5:0]  rd_reg2,
  output logic        hazard1,
  output logic        hazard2,
`ifdef WBQ_BYPASS_EN
  output logic [63:0] fwd1_data,
  output logic [63:0] fwd2_data,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
`endif
  output logic        wr_en,
  output logic [5:0]  wr_reg,
  output logic [63:0] wr_data
);
  localparam int AW = $clog2(DEPTH);

  logic [5:0]       reg_q [DEPTH];
  logic [5:0]       reg_d [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [63:0]      data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [5:0]       wr_reg_q, wr_reg_d;
  logic [63:0]      wr_data_q, wr_data_d;
  logic             push, alu_ok, pop, head_ok;
  logic [5:0]       rd [2];
  logic             hit [2];

  function automatic logic disc(input logic [5:0] idx);
    return (idx == 6'(ZERO_REG)) || idx[5];
  endfunction

  assign ld_ready = (cnt_q != (AW+1)'(DEPTH));
  // Discardable loads still complete the handshake but never occupy a slot.
  assign push     = ld_valid && ld_ready && !disc(ld_reg);
  assign alu_ok   = alu_valid && !disc(alu_reg);
  assign pop      = !alu_ok && (cnt_q != '0);
  assign head_ok  = pop && vld_q[rptr_q];

  always_comb begin
    reg_d  = reg_q;
    data_d = data_q;
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    for (int i = 0; i < DEPTH; i++)
      if (alu_valid && reg_q[i] == alu_reg) vld_d[i] = 1'b0;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    if (push) begin
      reg_d[wptr_q]  = ld_reg;
      data_d[wptr_q] = ld_data;
      vld_d[wptr_q]  = !(alu_valid && alu_reg == ld_reg);
      wptr_d         = wptr_q + 1'b1;
    end
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_en_d   = alu_ok || head_ok;
    wr_reg_d  = alu_ok ? alu_reg : head_ok ? reg_q[rptr_q] : wr_reg_q;
    wr_data_d = alu_ok ? alu_data : head_ok ? data_q[rptr_q] : wr_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
      vld_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      reg_q     <= reg_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rd[0] = rd_reg1;
  assign rd[1] = rd_reg2;

`ifdef WBQ_BYPASS_EN
  logic [63:0] fdat [2];
`endif

  // Walk head to tail so the youngest FIFO match wins; the wr_* stage overrides.
  always_comb begin : match_c
    logic [AW-1:0] idx;
    idx = '0;
    for (int k = 0; k < 2; k++) begin
      hit[k] = 1'b0;
`ifdef WBQ_BYPASS_EN
      fdat[k] = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        idx = rptr_q + AW'(i);
        if (vld_q[idx] && reg_q[idx] == rd[k]) begin
          hit[k] = 1'b1;
`ifdef WBQ_BYPASS_EN
          fdat[k] = data_q[idx];
`endif
        end
      end
      if (wr_en_q && wr_reg_q == rd[k]) begin
        hit[k] = 1'b1;
`ifdef WBQ_BYPASS_EN
        fdat[k] = wr_data_q;
`endif
      end
      if (disc(rd[k])) hit[k] = 1'b0;
    end
  end

`ifdef WBQ_BYPASS_EN
  assign hazard1   = 1'b0;
  assign hazard2   = 1'b0;
  assign fwd1_hit  = hit[0];
  assign fwd2_hit  = hit[1];
  assign fwd1_data = hit[0] ? fdat[0] : '0;
  assign fwd2_data = hit[1] ? fdat[1] : '0;
`else
  assign hazard1 = hit[0];
  assign hazard2 = hit[1];
`endif

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed checks of write-port arbitration, load queueing, squash, discard and reset.
module tb_wb_write_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid;
  logic [5:0]  alu_reg, ld_reg, rd_reg1, rd_reg2;
  logic [63:0] alu_data, ld_data;
  logic        ld_ready, hazard1, hazard2, wr_en;
  logic [5:0]  wr_reg;
  logic [63:0] wr_data;
  int          total = 0;
  int          bad   = 0;

  wb_write_queue #(.DEPTH(4), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard1(hazard1), .hazard2(hazard2),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_chk(input string tag, input logic en, input logic [5:0] r, input logic [63:0] d);
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(en));
    chk({tag, ".wr_reg"}, 64'(wr_reg), 64'(r));
    chk({tag, ".wr_data"}, wr_data, d);
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 0; alu_reg = 0; alu_data = 0;
    ld_valid = 0; ld_reg = 0; ld_data = 0; rd_reg1 = 0; rd_reg2 = 0;
    #12;
    wr_chk("reset", 0, 0, 0);
    chk("reset.ld_ready", 64'(ld_ready), 1);
    chk("reset.hazard1", 64'(hazard1), 0);
    chk("reset.hazard2", 64'(hazard2), 0);
    rst_n = 1'b1;
    tick();

    // single ALU write, latency 1
    alu_valid = 1; alu_reg = 5; alu_data = 64'hA5; rd_reg1 = 5;
    tick();
    alu_valid = 0;
    wr_chk("alu1", 1, 5, 64'hA5);
    chk("alu1.hazard1", 64'(hazard1), 1);
    tick();
    wr_chk("alu1.idle", 0, 5, 64'hA5);
    chk("alu1.idle.hazard1", 64'(hazard1), 0);

    // load waits behind three ALU writes
    alu_valid = 1; alu_reg = 7; alu_data = 64'h70;
    ld_valid = 1; ld_reg = 3; ld_data = 64'h33; rd_reg1 = 3;
    tick();
    ld_valid = 0; alu_reg = 8; alu_data = 64'h80;
    wr_chk("seq.7", 1, 7, 64'h70);
    chk("seq.7.hazard1", 64'(hazard1), 1);
    tick();
    alu_reg = 9; alu_data = 64'h90;
    wr_chk("seq.8", 1, 8, 64'h80);
    chk("seq.8.hazard1", 64'(hazard1), 1);
    tick();
    alu_valid = 0;
    wr_chk("seq.9", 1, 9, 64'h90);
    chk("seq.9.hazard1", 64'(hazard1), 1);
    tick();
    wr_chk("seq.3", 1, 3, 64'h33);
    chk("seq.3.hazard1", 64'(hazard1), 1);
    tick();
    chk("seq.done.wr_en", 64'(wr_en), 0);
    chk("seq.done.hazard1", 64'(hazard1), 0);

    // fill FIFO while ALU holds the port
    alu_valid = 1; alu_reg = 20; alu_data = 64'h200; rd_reg2 = 14;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_reg = 6'(11 + i); ld_data = 64'(8'h11 + i);
      chk("fill.ld_ready", 64'(ld_ready), 1);
      tick();
    end
    chk("full.ld_ready", 64'(ld_ready), 0);
    chk("full.hazard2", 64'(hazard2), 1);
    ld_reg = 15; ld_data = 64'h15;
    tick();
    chk("full.5th.ld_ready", 64'(ld_ready), 0);
    ld_valid = 0; alu_valid = 0;
    tick();
    wr_chk("drain.11", 1, 11, 64'h11);
    chk("drain.ld_ready", 64'(ld_ready), 1);
    tick();
    wr_chk("drain.12", 1, 12, 64'h12);
    tick();
    wr_chk("drain.13", 1, 13, 64'h13);
    tick();
    wr_chk("drain.14", 1, 14, 64'h14);
    tick();
    chk("drain.end.wr_en", 64'(wr_en), 0);
    chk("drain.end.hazard2", 64'(hazard2), 0);

    // WAW squash of a queued load by a younger ALU write
    ld_valid = 1; ld_reg = 10; ld_data = 64'h1; rd_reg1 = 10;
    tick();
    ld_valid = 0;
    chk("squash.queued.hazard1", 64'(hazard1), 1);
    alu_valid = 1; alu_reg = 10; alu_data = 64'h2;
    tick();
    alu_valid = 0;
    wr_chk("squash.alu", 1, 10, 64'h2);
    tick();
    wr_chk("squash.pop", 0, 10, 64'h2);
    chk("squash.hazard1", 64'(hazard1), 0);
    tick();
    chk("squash.after.wr_en", 64'(wr_en), 0);

    // discardable indices
    rd_reg1 = 31;
    alu_valid = 1; alu_reg = 31; alu_data = 64'hDEAD;
    ld_valid = 1; ld_reg = 31; ld_data = 64'hBEEF;
    chk("zero.ld_ready", 64'(ld_ready), 1);
    tick();
    alu_reg = 6'h25; ld_valid = 0;
    chk("zero.wr_en", 64'(wr_en), 0);
    chk("zero.hazard1", 64'(hazard1), 0);
    tick();
    alu_valid = 0;
    chk("bit5.wr_en", 64'(wr_en), 0);
    tick();
    chk("zero.drain.wr_en", 64'(wr_en), 0);
    chk("zero.ld_ready2", 64'(ld_ready), 1);

    // asynchronous reset with 3 loads queued
    alu_valid = 1; alu_reg = 21; alu_data = 64'h21; rd_reg1 = 1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_reg = 6'(1 + i); ld_data = 64'(i + 1);
      tick();
    end
    ld_valid = 0;
    chk("prerst.wr_en", 64'(wr_en), 1);
    chk("prerst.hazard1", 64'(hazard1), 1);
    #2 rst_n = 0;
    #1;
    chk("arst.wr_en", 64'(wr_en), 0);
    chk("arst.ld_ready", 64'(ld_ready), 1);
    chk("arst.hazard1", 64'(hazard1), 0);
    alu_valid = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst.wr_en", 64'(wr_en), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
